// File: rtl/rr_arb_pkg.sv
// ============================================================================
// rr_arb_pkg : shared types, sizes and the rotating-priority search helper
// Rev 1.0
// ============================================================================
`default_nettype none

package rr_arb_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  // Scans last+1, last+2, ... and wraps, so 'last' itself is examined last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                              input logic [ID_W-1:0]  last);
    logic [ID_W-1:0] idx;
    logic [ID_W-1:0] win;
    logic            found;
    win   = last;
    found = 1'b0;
    for (int i = 1; i <= N_REQ; i++) begin
      idx = last + ID_W'(i);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
    return win;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decoder_3_to_8.sv
// ============================================================================
// decoder_3_to_8 : enabled 3-to-8 binary to one-hot decoder
// Rev 1.0
// ============================================================================
`default_nettype none

module decoder_3_to_8
  import rr_arb_pkg::*;
(
  input  logic              en,
  input  logic [ID_W-1:0]   a,
  output logic [N_REQ-1:0]  out
);

  always_comb begin
    out = '0;
    if (en) begin
      out[a] = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rr_decoder_arbiter_8.sv
// ============================================================================
// rr_decoder_arbiter_8 : 8-way round-robin arbiter with hold limit and dead cycle
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_decoder_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_REQ-1:0]  req,
  output logic [N_REQ-1:0]  gnt,
  output logic [ID_W-1:0]   gnt_id,
  output logic              gnt_valid,
  output logic              timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e        state_q,     state_d;
  logic [N_REQ-1:0]  req_q,       req_d;
  logic [ID_W-1:0]   gnt_id_q,    gnt_id_d;
  logic [ID_W-1:0]   last_id_q,   last_id_d;
  logic [CNT_W-1:0]  hold_cnt_q,  hold_cnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic              timeout_q,   timeout_d;

  logic [ID_W-1:0]   winner;
  logic              any_req;

  // Requests are registered once, so the arbiter never sees req combinationally.
  assign req_d   = req;
  assign winner  = rr_pick(req_q, last_id_q);
  assign any_req = |req_q;

  always_comb begin
    state_d     = state_q;
    gnt_id_d    = gnt_id_q;
    last_id_d   = last_id_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_valid_d = 1'b0;
    timeout_d   = 1'b0;

    case (state_q)
      IDLE, GAP: begin
        if (any_req) begin
          state_d     = GRANT;
          gnt_id_d    = winner;
          hold_cnt_d  = '0;
          gnt_valid_d = 1'b1;
        end else begin
          state_d     = IDLE;
        end
      end

      GRANT: begin
        if (hold_cnt_q != HOLD_LAST) begin
          hold_cnt_d = hold_cnt_q + CNT_W'(1);
        end
        if (!req_q[gnt_id_q]) begin
          last_id_d = gnt_id_q;
          state_d   = GAP;
        end else if (hold_cnt_q == HOLD_LAST) begin
          last_id_d = gnt_id_q;
          state_d   = GAP;
          timeout_d = 1'b1;
        end else begin
          gnt_valid_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      req_q       <= '0;
      gnt_id_q    <= '0;
      last_id_q   <= ID_W'(N_REQ - 1);
      hold_cnt_q  <= '0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      gnt_id_q    <= gnt_id_d;
      last_id_q   <= last_id_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
    end
  end

  decoder_3_to_8 u_dec (
    .en  (gnt_valid_q),
    .a   (gnt_id_q),
    .out (gnt)
  );

  assign gnt_id    = gnt_id_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_decoder_arbiter_8.sv
// ============================================================================
// tb_rr_decoder_arbiter_8 : directed + random bench against a cycle reference model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_rr_decoder_arbiter_8;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  always #5 clk = ~clk;

  rr_decoder_arbiter_8 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .gnt       (gnt),
    .gnt_id    (gnt_id),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: requests are seen one cycle late; an owner keeps the
  // resource for up to MH cycles, then one idle cycle precedes the next pick.
  bit [7:0] m_seen;
  bit       m_busy;
  int       m_owner;
  int       m_last;
  int       m_held;
  bit       m_to;

  function automatic void m_reset();
    m_seen  = 8'h00;
    m_busy  = 1'b0;
    m_owner = 0;
    m_last  = 7;
    m_held  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void m_edge();
    bit [7:0] r;
    bit       found;
    r      = m_seen;
    m_seen = req;
    m_to   = 1'b0;
    if (m_busy) begin
      if (!r[m_owner]) begin
        m_busy = 1'b0;
        m_last = m_owner;
      end else if (m_held == MH) begin
        m_busy = 1'b0;
        m_last = m_owner;
        m_to   = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      found = 1'b0;
      for (int k = 1; k <= 8; k++) begin
        int c;
        c = (m_last + k) % 8;
        if (!found && r[c]) begin
          found   = 1'b1;
          m_busy  = 1'b1;
          m_owner = c;
          m_held  = 1;
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    logic [7:0] one;
    one = 8'h01;
    chk("gnt",       32'(gnt),       m_busy ? 32'(one << m_owner) : 32'h0);
    chk("gnt_valid", 32'(gnt_valid), 32'(m_busy));
    chk("gnt_id",    32'(gnt_id),    32'(m_owner));
    chk("timeout",   32'(timeout),   32'(m_to));
    chk("onehot0",   32'($onehot0(gnt)), 32'h1);
    chk("valid_or",  32'(gnt_valid), 32'(|gnt));
    chk("decode",    32'(gnt),       32'(8'(gnt_valid) << gnt_id));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst_n) m_reset();
    else        m_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    m_reset();
    step();
    step();
    rst_n = 1'b1;
  endtask

  int       cnt;
  int       cur;
  int       to_seen;
  bit       prev_v;
  int       owners[$];
  int       first_len;

  initial begin
    // Reset with everyone requesting
    rst_n = 1'b0;
    req   = 8'hFF;
    m_reset();
    repeat (2) @(negedge clk);
    check_all();
    rst_n = 1'b1;
    step();
    chk("t1_gnt_after_1", 32'(gnt), 32'h00);
    step();
    chk("t1_gnt_after_2", 32'(gnt), 32'h01);
    req = 8'h00;
    repeat (6) step();

    // Single requester held for three cycles
    req = 8'h10;
    cnt = 0;
    repeat (3) begin step(); if (gnt == 8'h10) cnt++; end
    req = 8'h00;
    repeat (5) begin step(); if (gnt == 8'h10) cnt++; end
    chk("t2_cycles", 32'(cnt), 32'd3);
    chk("t2_id", 32'(gnt_id), 32'd4);

    // Rotation: everyone requests, owners drop after two granted cycles
    do_reset();
    req = 8'hFF;
    owners.delete();
    prev_v = 1'b0;
    cur = 0;
    for (int s = 0; s < 80 && owners.size() < 9; s++) begin
      step();
      if (gnt_valid && !prev_v) owners.push_back(int'(gnt_id));
      if (gnt_valid) begin
        cur++;
        if (cur == 2) req[gnt_id] = 1'b0;
      end else begin
        cur = 0;
        req = 8'hFF;
      end
      prev_v = gnt_valid;
    end
    chk("t3_count", 32'(owners.size()), 32'd9);
    for (int i = 0; i < owners.size(); i++) chk("t3_order", 32'(owners[i]), 32'(i % 8));
    req = 8'h00;
    repeat (6) step();

    // Timeout with a competing requester
    do_reset();
    req = 8'h05;
    owners.delete();
    prev_v = 1'b0;
    to_seen = 0;
    first_len = 0;
    repeat (16) begin
      step();
      if (gnt_valid && !prev_v) owners.push_back(int'(gnt_id));
      if (gnt == 8'h01 && owners.size() == 1) first_len++;
      if (timeout) to_seen++;
      prev_v = gnt_valid;
    end
    chk("t4_first_len", 32'(first_len), 32'(MH));
    chk("t4_timeout_seen", 32'(to_seen > 0), 32'h1);
    chk("t4_second_owner", 32'(owners.size() > 1 ? owners[1] : -1), 32'd2);
    req = 8'h00;
    repeat (8) step();

    // Wrap: last owner 6, then requesters 0 and 6 both ask
    do_reset();
    req = 8'h40;
    repeat (3) step();
    req = 8'h00;
    repeat (6) step();
    req = 8'h41;
    repeat (2) step();
    chk("t5_wrap", 32'(gnt), 32'h01);
    req = 8'h00;
    repeat (6) step();

    // Asynchronous reset in the middle of a grant
    do_reset();
    req = 8'h20;
    repeat (3) step();
    chk("t6_pre", 32'(gnt), 32'h20);
    #2 rst_n = 1'b0;
    #1;
    m_reset();
    chk("t6_async_gnt", 32'(gnt), 32'h00);
    chk("t6_async_valid", 32'(gnt_valid), 32'h0);
    req = 8'h21;
    step();
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("t6_restart", 32'(gnt), 32'h01);
    req = 8'h00;
    repeat (6) step();

    // Random traffic with sticky requests
    do_reset();
    req = 8'h00;
    repeat (600) begin
      req = req ^ 8'($urandom & $urandom & $urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
